// File: rtl/ehgu_basic_pkg.sv
// ----------------------------------------------------------------------------
// ehgu_basic_pkg
//
// Shared types and helpers for the ehgu FIFO family.
//
//   arb_state_t : two-state burst arbiter FSM encoding (IDLE, BURST)
//   rr_pick()   : round-robin search over a request vector, starting one
//                 above the previously granted index and wrapping at nreq
//
// rr_pick works on a fixed-width container of RR_MAX_REQ bits. Callers with
// fewer requesters zero-extend their vectors and pass their real requester
// count, so one function serves every NREQ from 2 to RR_MAX_REQ.
// ----------------------------------------------------------------------------
package ehgu_basic_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    // Returns the first set bit of req found by walking (last+1), (last+2), ...
    // modulo nreq. When no bit is set the previous index is returned; callers
    // qualify the result with their own any-request flag.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   last,
        input int                    nreq
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            idx = (int'(last) + k) % nreq;
            if (!found && (k <= nreq) && req[RR_IDX_W'(idx)]) begin
                pick  = RR_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ehgu_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ehgu_rr_arbiter
//
// Purely combinational round-robin selector. Shared by the write-port
// arbiter and any read-side scheduler that needs the same fairness rule.
//
// Parameters:
//   NREQ    number of requesters (2..16)
// Ports:
//   req     in   NREQ  request vector
//   last    in   IDW   index granted last time; search starts one above it
//   grant   out  IDW   winning index (meaningful only when any_req is high)
//   any_req out  1     at least one request bit is set
// ----------------------------------------------------------------------------
module ehgu_rr_arbiter
    import ehgu_basic_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  grant,
    output logic            any_req
);

    logic [RR_MAX_REQ-1:0] req_ext;
    logic [RR_IDX_W-1:0]   last_ext;
    logic [RR_IDX_W-1:0]   pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NREQ-1:0]    = req;
        last_ext             = '0;
        last_ext[IDW-1:0]    = last;
        pick                 = rr_pick(req_ext, last_ext, NREQ);
        grant                = IDW'(pick);
        any_req              = |req;
    end

endmodule

// File: rtl/ehgu_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// ehgu_fifo_wr_arbiter
//
// Shares the single write port of a synchronous ehgu FIFO between NREQ
// requesters. A round-robin winner is granted a burst of up to MAX_BURST
// beats; the burst ends early on req_last or when en drops. The FIFO level
// is tracked here from accepted writes and consumer pops, and all requesters
// are back-pressured while the FIFO is full.
//
// Parameters:
//   NREQ       number of requesters (2..16)
//   WIDTH      data bits per beat
//   DEPTH      FIFO depth in entries (>= 2, any value)
//   CWIDTH     level counter width, 2**CWIDTH > DEPTH
//   MAX_BURST  beats per grant (>= 1)
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   en                arbitration enable
//   req_valid/_data/_last, req_ready   per-requester beat handshake
//   fifo_din_valid, fifo_din           FIFO write strobe and data
//   fifo_pop          one entry consumed by the FIFO reader
//   grant_id          current or most recent grant
//   level, full, empty                 FIFO occupancy
//   err_underflow     sticky: pop seen while level was 0
// ----------------------------------------------------------------------------
module ehgu_fifo_wr_arbiter
    import ehgu_basic_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 128,
    parameter  int CWIDTH    = 8,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = $clog2(NREQ),
    localparam int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   fifo_din_valid,
    output logic [WIDTH-1:0]       fifo_din,
    input  logic                   fifo_pop,
    output logic [IDW-1:0]         grant_id,
    output logic [CWIDTH-1:0]      level,
    output logic                   full,
    output logic                   empty,
    output logic                   err_underflow
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t          state_reg,      state_next;
    logic [IDW-1:0]      grant_id_reg,   grant_id_next;
    logic [IDW-1:0]      last_grant_reg, last_grant_next;
    logic [BCW-1:0]      beat_cnt_reg,   beat_cnt_next;
    logic [CWIDTH-1:0]   level_reg,      level_next;
    logic                err_underflow_reg, err_underflow_next;

    // ------------------------------------------------------------------
    // Per-requester data lanes
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    req_data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign req_data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic [IDW-1:0]      rr_grant;
    logic                rr_any;

    ehgu_rr_arbiter #(
        .NREQ    (NREQ)
    ) u_rr (
        .req     (req_valid),
        .last    (last_grant_reg),
        .grant   (rr_grant),
        .any_req (rr_any)
    );

    // ------------------------------------------------------------------
    // Occupancy decode (from registered level only, so fifo_pop never
    // reaches req_ready combinationally)
    // ------------------------------------------------------------------
    logic full_int;
    logic empty_int;

    assign full_int  = (level_reg == CWIDTH'(DEPTH));
    assign empty_int = (level_reg == '0);

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    logic can_accept;
    logic accept;
    logic burst_done;

    always_comb begin
        can_accept     = (state_reg == BURST) && en && !full_int;
        accept         = can_accept && req_valid[grant_id_reg];
        fifo_din_valid = accept;
        fifo_din       = req_data_arr[grant_id_reg];
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = can_accept && (grant_id_reg == IDW'(gi));
        end
    endgenerate

    // The beat being accepted now is the last one the grant allows.
    assign burst_done = (beat_cnt_reg == BCW'(MAX_BURST - 1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        grant_id_next   = grant_id_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (en && !full_int && rr_any) begin
                    state_next    = BURST;
                    grant_id_next = rr_grant;
                    beat_cnt_next = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt_reg + BCW'(1);
                end
                // A stalled or idle requester keeps the grant; only last,
                // burst length or en low release it.
                if (!en || (accept && (req_last[grant_id_reg] || burst_done))) begin
                    state_next      = IDLE;
                    last_grant_next = grant_id_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Level counter and underflow flag
    // ------------------------------------------------------------------
    logic pop_eff;

    always_comb begin
        pop_eff            = fifo_pop && !empty_int;
        level_next         = level_reg + CWIDTH'(accept) - CWIDTH'(pop_eff);
        err_underflow_next = err_underflow_reg || (fifo_pop && empty_int);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg         <= IDLE;
            grant_id_reg      <= '0;
            last_grant_reg    <= IDW'(NREQ - 1);
            beat_cnt_reg      <= '0;
            level_reg         <= '0;
            err_underflow_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            grant_id_reg      <= grant_id_next;
            last_grant_reg    <= last_grant_next;
            beat_cnt_reg      <= beat_cnt_next;
            level_reg         <= level_next;
            err_underflow_reg <= err_underflow_next;
        end
    end

    assign grant_id      = grant_id_reg;
    assign level         = level_reg;
    assign full          = full_int;
    assign empty         = empty_int;
    assign err_underflow = err_underflow_reg;

endmodule

// File: tb/tb_ehgu_fifo_wr_arbiter.sv
module tb_ehgu_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 6;
    localparam int CWIDTH    = 3;
    localparam int MAX_BURST = 4;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_din_valid;
    logic [WIDTH-1:0]      fifo_din;
    logic                  fifo_pop;
    logic [1:0]            grant_id;
    logic [CWIDTH-1:0]     level;
    logic                  full;
    logic                  empty;
    logic                  err_underflow;

    always #5 clk = ~clk;

    ehgu_fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .CWIDTH    (CWIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_din_valid (fifo_din_valid),
        .fifo_din       (fifo_din),
        .fifo_pop       (fifo_pop),
        .grant_id       (grant_id),
        .level          (level),
        .full           (full),
        .empty          (empty),
        .err_underflow  (err_underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side sequence numbers (advance on handshake) and the
    // scoreboard's own expected sequence numbers (advance on push).
    logic [3:0] seq     [NREQ];
    logic [3:0] exp_seq [NREQ];
    logic [3:0] last_seq[NREQ];
    bit         last_en [NREQ];

    logic [WIDTH-1:0] exp_q[$];
    logic [1:0]       gnt_log[$];

    // Expected occupancy / sticky error, tracked from observed traffic.
    int  m_level = 0;
    bit  m_err   = 0;
    bit  auto_pop = 0;
    int  n_acc = 0;

    // Snapshot of the current cycle's outputs (taken on the falling edge).
    logic            s_valid;
    logic [NREQ-1:0] s_ready;
    logic [CWIDTH-1:0] s_level;
    logic            s_full;
    logic [1:0]      s_grant;
    logic            s_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = {4'(i), seq[i]};
            req_last[i] = last_en[i] && (last_seq[i] == seq[i]);
        end
    endtask

    task automatic push_burst(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({4'(id), exp_seq[id]});
            exp_seq[id] = exp_seq[id] + 4'd1;
        end
    endtask

    task automatic check_log(input string tag, input int n, input logic [1:0] g0,
                             input logic [1:0] g1, input logic [1:0] g2,
                             input logic [1:0] g3, input logic [1:0] g4);
        logic [1:0] exp_g [5];
        exp_g[0] = g0; exp_g[1] = g1; exp_g[2] = g2; exp_g[3] = g3; exp_g[4] = g4;
        check({tag, "_count"}, gnt_log.size(), n);
        for (int k = 0; k < n && k < gnt_log.size(); k++) begin
            check($sformatf("%s_%0d", tag, k), gnt_log[k], exp_g[k]);
        end
    endtask

    // One clock cycle: sample and check on the falling edge, then advance
    // the requester model just after the rising edge.
    task automatic cycle();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        s_valid = fifo_din_valid;
        s_ready = req_ready;
        s_level = level;
        s_full  = full;
        s_grant = grant_id;
        s_err   = err_underflow;
        check("level", level, m_level);
        check("full", full, m_level == DEPTH);
        check("empty", empty, m_level == 0);
        check("err_underflow", err_underflow, m_err);
        if (fifo_din_valid) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                check("fifo_din_valid_unexpected", fifo_din_valid, 1'b0);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("fifo_din", fifo_din, e);
                $display("beat: grant=%0d data=%02h expected=%02h level=%0d", grant_id, fifo_din, e, level);
            end
            if (gnt_log.size() == 0 || gnt_log[$] != grant_id) gnt_log.push_back(grant_id);
        end
        if (fifo_pop && m_level == 0) m_err = 1;
        m_level = m_level + (fifo_din_valid ? 1 : 0) - ((fifo_pop && m_level != 0) ? 1 : 0);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (hs[i]) seq[i] = seq[i] + 4'd1;
        if (auto_pop) fifo_pop = (m_level != 0);
        drive_data();
    endtask

    task automatic drain();
        auto_pop = 1;
        for (int k = 0; k < 12 && m_level != 0; k++) cycle();
        auto_pop = 0;
        fifo_pop = 0;
        cycle();
        check("drain_level", s_level, 0);
    endtask

    initial begin
        int max_lvl;
        rstn = 0; en = 0; req_valid = '0; fifo_pop = 0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i] = '0; exp_seq[i] = '0; last_seq[i] = '0; last_en[i] = 0;
        end
        drive_data();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, '0);
        check("rst_din_valid", fifo_din_valid, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_err", err_underflow, 0);
        check("rst_grant", grant_id, 0);
        @(posedge clk);
        #1;
        rstn = 1;

        // ---- single burst from requester 0 ----
        en = 1; req_valid = 4'b0001; drive_data();
        push_burst(0, 4);
        cycle();
        check("t1_idle_ready", s_ready, '0);
        check("t1_idle_valid", s_valid, 0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t1_beat_valid", s_valid, 1);
            check("t1_beat_grant", s_grant, 0);
            check("t1_beat_ready", s_ready, 4'b0001);
        end
        req_valid = '0; drive_data();
        cycle();
        check("t1_bubble_valid", s_valid, 0);
        check("t1_bubble_ready", s_ready, '0);
        check("t1_level", s_level, 4);
        check("t1_q_empty", exp_q.size(), 0);
        drain();

        // ---- round robin with continuous consumption ----
        gnt_log.delete();
        auto_pop = 1;
        req_valid = 4'b1111; drive_data();
        push_burst(1, 4); push_burst(2, 4); push_burst(3, 4); push_burst(0, 4); push_burst(1, 4);
        max_lvl = 0;
        for (int k = 0; k < 25; k++) begin
            cycle();
            if (int'(s_level) > max_lvl) max_lvl = int'(s_level);
        end
        req_valid = '0; drive_data();
        cycle();
        check("rr_bubble_valid", s_valid, 0);
        check("rr_max_level_le1", max_lvl <= 1, 1);
        check_log("rr_order", 5, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1);
        check("rr_q_empty", exp_q.size(), 0);

        // ---- early last from requester 2 ----
        gnt_log.delete();
        last_en[2] = 1; last_seq[2] = exp_seq[2] + 4'd1;
        req_valid = 4'b1101; drive_data();
        push_burst(2, 2); push_burst(3, 4);
        repeat (8) cycle();
        req_valid = '0; last_en[2] = 0; drive_data();
        cycle();
        check_log("last_order", 2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0);
        check("last_q_empty", exp_q.size(), 0);
        drain();

        // ---- full stall, no consumption ----
        gnt_log.delete();
        n_acc = 0;
        req_valid = 4'b0010; drive_data();
        push_burst(1, 7);
        repeat (10) cycle();
        check("full_acc6", n_acc, 6);
        check("full_flag", s_full, 1);
        check("full_ready", s_ready, '0);
        check("full_grant", s_grant, 1);
        fifo_pop = 1;
        cycle();
        check("full_pop_blocks", s_valid, 0);
        fifo_pop = 0;
        cycle();
        check("full_after_pop_level", s_level, 5);
        check("full_after_pop_accept", s_valid, 1);
        cycle();
        check("full_again", s_full, 1);
        check("full_again_ready", s_ready, '0);
        check("full_acc7", n_acc, 7);
        req_valid = '0; drive_data();
        drain();

        // ---- underflow ----
        fifo_pop = 1;
        cycle();
        fifo_pop = 0;
        cycle();
        check("uf_err", s_err, 1);
        check("uf_level", s_level, 0);
        cycle();
        check("uf_sticky", s_err, 1);

        // ---- en low releases the held grant; then reset mid-burst ----
        en = 0;
        cycle();
        check("en_low_ready", s_ready, '0);
        en = 1;
        gnt_log.delete();
        req_valid = 4'b0101; drive_data();
        push_burst(2, 1);
        cycle();
        cycle();
        check("pre_rst_grant", s_grant, 2);
        @(negedge clk);
        check("pre_rst_beat2_valid", fifo_din_valid, 1);
        #2 rstn = 0;
        #1;
        check("mid_rst_ready", req_ready, '0);
        check("mid_rst_valid", fifo_din_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_full", full, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_err", err_underflow, 0);
        check("mid_rst_grant", grant_id, 0);
        @(posedge clk);
        #1;
        rstn = 1;
        m_level = 0; m_err = 0;
        gnt_log.delete();

        // After reset requester 0 wins; accept plus pop at level 3 holds level.
        push_burst(0, 4);
        cycle();
        check("post_rst_idle_valid", s_valid, 0);
        repeat (3) cycle();
        fifo_pop = 1;
        cycle();
        check("simul_level_before", s_level, 3);
        check("simul_accept", s_valid, 1);
        fifo_pop = 0;
        req_valid = '0; drive_data();
        cycle();
        check("simul_level_after", s_level, 3);
        check_log("post_rst_order", 1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        check("final_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
